cache_data_array: RTL and testbench

CACHE_DATA_ARRAY -- requirements
Module: cache_data_array

---
 rtl/cache_data_array.sv | 121 ++++++++++++
 tb/tb_cache_data_array.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_data_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cache_data_array: byte-writable cache data store with multi-beat refill   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cache_data_array #(
  parameter  int DATA_W         = 32,
  parameter  int WORDS_PER_LINE = 4,
  parameter  int LINES          = 32,
  parameter  int BUS_W          = 64,
  localparam int WPB            = BUS_W / DATA_W,
  localparam int BEATS          = WORDS_PER_LINE / WPB,
  localparam int DEPTH          = LINES * WORDS_PER_LINE,
  localparam int AW             = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [AW-1:0]       addr,
  input  logic                rd_en,
  input  logic                wr_en,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                refill_start,
  input  logic                beat_valid,
  input  logic [BUS_W-1:0]    beat_data,
  output logic                beat_ready,
  output logic                busy,
  output logic                refill_done,
  output logic [DATA_W-1:0]   rdata,
  output logic                rvalid
);

  localparam int OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int LINE_W = AW - OFF_W;
  localparam int NBYTES = DATA_W / 8;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] C_LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [LINE_W-1:0]   r_line;
  logic [BEAT_W-1:0]   r_beat;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic                w_xfer;
  logic                w_wr;
  logic [AW-1:0]       w_base;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    beat_ready  = 1'b0;
    case (r_state)
      S_IDLE: if (refill_start) w_state_nxt = S_FILL;
      S_FILL: begin
        busy       = 1'b1;
        beat_ready = 1'b1;
        if (beat_valid && (r_beat == C_LAST_BEAT)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_xfer = beat_ready & beat_valid;
  assign w_wr   = wr_en & (r_state == S_IDLE);
  // First word of the current beat within the latched line.
  assign w_base = {r_line, {OFF_W{1'b0}}} + AW'(r_beat) * AW'(WPB);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_line      <= '0;
      r_beat      <= '0;
      refill_done <= 1'b0;
    end else begin
      refill_done <= w_xfer && (r_beat == C_LAST_BEAT);
      if ((r_state == S_IDLE) && refill_start) begin
        r_line <= addr[AW-1:OFF_W];
        r_beat <= '0;
      end else if (w_xfer) begin
        r_beat <= (r_beat == C_LAST_BEAT) ? '0 : r_beat + 1'b1;
      end
    end
  end

  // Store writes only happen in IDLE and beats only in FILL, so they never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr) begin
        for (int b = 0; b < NBYTES; b++)
          if (wbe[b]) r_mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
      if (w_xfer) begin
        for (int j = 0; j < WPB; j++)
          r_mem[w_base + AW'(j)] <= beat_data[j*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_en;
      if (rd_en) rdata <= r_mem[addr];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_data_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cache_data_array: directed bench with cycle-level reference model      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_cache_data_array;
  localparam int DATA_W = 32, WPL = 4, LINES = 32, BUS_W = 64;
  localparam int WPB = BUS_W / DATA_W, BEATS = WPL / WPB, DEPTH = LINES * WPL, AW = 7;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [AW-1:0]     addr = '0;
  logic              rd_en = 1'b0, wr_en = 1'b0;
  logic [3:0]        wbe = '0;
  logic [31:0]       wdata = '0;
  logic              refill_start = 1'b0, beat_valid = 1'b0;
  logic [63:0]       beat_data = '0;
  logic              beat_ready, busy, refill_done, rvalid;
  logic [31:0]       rdata;

  int n_checks = 0, n_fail = 0;
  int busy_cnt = 0, done_cnt = 0;
  bit chk_en = 1'b0;

  cache_data_array #(.DATA_W(DATA_W), .WORDS_PER_LINE(WPL), .LINES(LINES), .BUS_W(BUS_W)) dut (
    .clk(clk), .reset(reset), .addr(addr), .rd_en(rd_en), .wr_en(wr_en), .wbe(wbe),
    .wdata(wdata), .refill_start(refill_start), .beat_valid(beat_valid),
    .beat_data(beat_data), .beat_ready(beat_ready), .busy(busy),
    .refill_done(refill_done), .rdata(rdata), .rvalid(rvalid)
  );

  always #5 clk = ~clk;

  // Reference model: memory contents plus refill progress as plain integers.
  logic [31:0] m_mem [DEPTH];
  bit          m_fill = 1'b0;
  int          m_line = 0, m_beats = 0;
  logic [31:0] e_rdata = '0;
  bit          e_rvalid = 1'b0, e_done = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      foreach (m_mem[i]) m_mem[i] = '0;
      m_fill = 1'b0; m_beats = 0; e_rdata = '0; e_rvalid = 1'b0; e_done = 1'b0;
    end else begin
      if (rd_en) e_rdata = m_mem[addr];
      e_rvalid = rd_en;
      e_done   = 1'b0;
      if (!m_fill) begin
        if (wr_en)
          for (int b = 0; b < 4; b++) if (wbe[b]) m_mem[addr][b*8 +: 8] = wdata[b*8 +: 8];
        if (refill_start) begin
          m_fill = 1'b1; m_line = int'(addr) / WPL; m_beats = 0;
        end
      end else if (beat_valid) begin
        for (int j = 0; j < WPB; j++)
          m_mem[m_line*WPL + m_beats*WPB + j] = beat_data[j*DATA_W +: DATA_W];
        m_beats++;
        if (m_beats == BEATS) begin
          m_fill = 1'b0; e_done = 1'b1;
        end
      end
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      cmp("rdata", rdata, e_rdata);
      cmp("rvalid", 32'(rvalid), 32'(e_rvalid));
      cmp("busy", 32'(busy), 32'(m_fill));
      cmp("beat_ready", 32'(beat_ready), 32'(m_fill));
      cmp("refill_done", 32'(refill_done), 32'(e_done));
    end
    if (busy) busy_cnt++;
    if (refill_done) done_cnt++;
  end

  task automatic rd(input logic [AW-1:0] a, output logic [31:0] d);
    rd_en = 1'b1; addr = a;
    @(negedge clk);
    rd_en = 1'b0; d = rdata;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wbe = be; wdata = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic refill(input logic [AW-1:0] a, input logic [63:0] b0, input logic [63:0] b1,
                        input int gap);
    refill_start = 1'b1; addr = a;
    @(negedge clk);
    refill_start = 1'b0; beat_valid = 1'b1; beat_data = b0;
    @(negedge clk);
    beat_valid = 1'b0;
    repeat (gap) @(negedge clk);
    beat_valid = 1'b1; beat_data = b1;
    @(negedge clk);
    beat_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] exp22 [4];
    exp22[0] = 32'h11111111; exp22[1] = 32'h22222222;
    exp22[2] = 32'h33333333; exp22[3] = 32'h44444444;
    foreach (m_mem[i]) m_mem[i] = '0;

    repeat (2) @(negedge clk);
    cmp("reset_busy", 32'(busy), 32'h0);
    cmp("reset_beat_ready", 32'(beat_ready), 32'h0);
    cmp("reset_refill_done", 32'(refill_done), 32'h0);
    cmp("reset_rvalid", 32'(rvalid), 32'h0);
    cmp("reset_rdata", rdata, 32'h0);
    reset = 1'b0; chk_en = 1'b1;
    @(negedge clk);

    rd(7'h2A, d);
    cmp("read_after_reset", d, 32'h0);
    cmp("rvalid_after_read", 32'(rvalid), 32'h1);

    // Read and write the same word in one cycle: old data returned.
    rd_en = 1'b1; wr_en = 1'b1; addr = 7'h01; wbe = 4'hF; wdata = 32'hFFFFFFFF;
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0;
    cmp("rbw_old", rdata, 32'h0);
    rd(7'h01, d);
    cmp("rbw_new", d, 32'hFFFFFFFF);

    busy_cnt = 0; done_cnt = 0;
    refill(7'h15, 64'h22222222_11111111, 64'h44444444_33333333, 1);
    @(negedge clk);
    cmp("refill_busy_cycles", 32'(busy_cnt), 32'd3);
    cmp("refill_done_pulses", 32'(done_cnt), 32'd1);
    for (int i = 0; i < 4; i++) begin
      rd(7'h14 + 7'(i), d);
      cmp("refill_word", d, exp22[i]);
    end

    wr(7'h16, 4'b0101, 32'hAABBCCDD);
    rd(7'h16, d);
    cmp("byte_enable_merge", d, 32'h33BB33DD);

    // Store during FILL must be dropped.
    refill_start = 1'b1; addr = 7'h15;
    @(negedge clk);
    refill_start = 1'b0; beat_valid = 1'b1; beat_data = 64'h66666666_55555555;
    @(negedge clk);
    beat_valid = 1'b0; wr_en = 1'b1; addr = 7'h14; wbe = 4'hF; wdata = 32'hCAFEF00D;
    @(negedge clk);
    wr_en = 1'b0; beat_valid = 1'b1; beat_data = 64'h88888888_77777777;
    @(negedge clk);
    beat_valid = 1'b0;
    rd(7'h14, d);
    cmp("write_in_fill_ignored", d, 32'h55555555);

    // Write and refill_start together: write lands, then the beat overwrites it.
    wr_en = 1'b1; wbe = 4'hF; wdata = 32'h12345678;
    refill(7'h17, 64'hAAAAAAAA_99999999, 64'hCCCCCCCC_BBBBBBBB, 0);
    wr_en = 1'b0;
    rd(7'h17, d);
    cmp("write_then_refill", d, 32'hCCCCCCCC);

    // Reset in the middle of a refill.
    busy_cnt = 0; done_cnt = 0;
    refill_start = 1'b1; addr = 7'h15;
    @(negedge clk);
    refill_start = 1'b0; beat_valid = 1'b1; beat_data = 64'hDEADBEEF_FEEDFACE;
    @(negedge clk);
    reset = 1'b1;
    #1;
    cmp("midfill_reset_busy", 32'(busy), 32'h0);
    cmp("midfill_reset_ready", 32'(beat_ready), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp("post_reset_ready", 32'(beat_ready), 32'h0);
    end
    beat_valid = 1'b0;
    cmp("post_reset_no_done", 32'(done_cnt), 32'd0);
    for (int i = 0; i < 4; i++) begin
      rd(7'h14 + 7'(i), d);
      cmp("post_reset_line", d, 32'h0);
    end

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
